// File: rtl/sw_input_conditioner.sv
// Conditions the raw slide-switch inputs for the complex-multiplier FSM.
// The handshake switch and the data switches are brought into the clk domain
// through two-flop synchronisers. The handshake is then debounced. The block
// emits one-cycle rise/fall strobes and captures the data word on each
// debounced rising edge.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset, released synchronously upstream
//   hs_raw    raw handshake switch (asynchronous)
//   data_raw  raw data-word switches (asynchronous)
//   hs_level  debounced handshake level
//   hs_rise   one-cycle strobe on a debounced 0->1
//   hs_fall   one-cycle strobe on a debounced 1->0
//   data_out  word captured on hs_rise, held otherwise
//   busy      high while a handshake level change is being qualified
module sw_input_conditioner #(
    parameter int unsigned WORD_W          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hs_raw,
    input  logic [WORD_W-1:0] data_raw,
    output logic              hs_level,
    output logic              hs_rise,
    output logic              hs_fall,
    output logic [WORD_W-1:0] data_out,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_RISING  = 2'd1,
        ST_HIGH    = 2'd2,
        ST_FALLING = 2'd3
    } state_t;

    logic              hs_s1;
    logic              hs_s;
    logic [WORD_W-1:0] dat_s1;
    logic [WORD_W-1:0] dat_s;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              rise_nxt;
    logic              fall_nxt;
    logic              level_nxt;
    logic              busy_nxt;
    logic [WORD_W-1:0] data_nxt;

    // Two-flop synchronisers, no logic between the stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_s1  <= 1'b0;
            hs_s   <= 1'b0;
            dat_s1 <= '0;
            dat_s  <= '0;
        end else begin
            hs_s1  <= hs_raw;
            hs_s   <= hs_s1;
            dat_s1 <= data_raw;
            dat_s  <= dat_s1;
        end
    end

    // cnt holds the number of consecutive differing cycles already seen,
    // so cnt_inc is the count including the current cycle. It never exceeds
    // DEBOUNCE_CYCLES because reaching it forces the level change.
    assign cnt_inc = cnt + CNT_W'(1);

    // Next-state logic: a new level is accepted on the edge where it has
    // been present on hs_s for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        data_nxt  = data_out;
        case (state)
            ST_LOW, ST_RISING: begin
                if (!hs_s) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                    data_nxt  = dat_s;
                end else begin
                    state_nxt = ST_RISING;
                    cnt_nxt   = cnt_inc;
                end
            end
            ST_HIGH, ST_FALLING: begin
                if (hs_s) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_FALLING;
                    cnt_nxt   = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
        level_nxt = (state_nxt == ST_HIGH) || (state_nxt == ST_FALLING);
        busy_nxt  = (state_nxt == ST_RISING) || (state_nxt == ST_FALLING);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_LOW;
            cnt      <= '0;
            hs_level <= 1'b0;
            hs_rise  <= 1'b0;
            hs_fall  <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            hs_level <= level_nxt;
            hs_rise  <= rise_nxt;
            hs_fall  <= fall_nxt;
            data_out <= data_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_sw_input_conditioner.sv
module tb_sw_input_conditioner;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned DEB    = 4;
    // Edges from an input change to the strobe being visible: two
    // synchroniser stages plus DEB qualifying cycles.
    localparam int LAT = DEB + 2;

    logic              clk;
    logic              reset_n;
    logic              hs_raw;
    logic [WORD_W-1:0] data_raw;
    logic              hs_level;
    logic              hs_rise;
    logic              hs_fall;
    logic [WORD_W-1:0] data_out;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_rise   = 0;
    int n_fall   = 0;

    sw_input_conditioner #(
        .WORD_W          (WORD_W),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hs_raw   (hs_raw),
        .data_raw (data_raw),
        .hs_level (hs_level),
        .hs_rise  (hs_rise),
        .hs_fall  (hs_fall),
        .data_out (data_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the switch value seen by the conditioner is the raw
    // sample from two edges earlier; a level is accepted once it has
    // disagreed with the current level for DEB consecutive cycles.
    logic              hist_hs [2];
    logic [WORD_W-1:0] hist_d  [2];
    logic              m_level;
    logic              m_rise;
    logic              m_fall;
    logic [WORD_W-1:0] m_data;
    int                m_run;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_hs[0] <= 1'b0;
            hist_hs[1] <= 1'b0;
            hist_d[0]  <= '0;
            hist_d[1]  <= '0;
            m_level    <= 1'b0;
            m_rise     <= 1'b0;
            m_fall     <= 1'b0;
            m_data     <= '0;
            m_run      <= 0;
        end else begin
            hist_hs[0] <= hs_raw;
            hist_hs[1] <= hist_hs[0];
            hist_d[0]  <= data_raw;
            hist_d[1]  <= hist_d[0];
            m_rise     <= 1'b0;
            m_fall     <= 1'b0;
            if (hist_hs[1] != m_level) begin
                if (m_run + 1 == DEB) begin
                    m_level <= hist_hs[1];
                    m_run   <= 0;
                    if (hist_hs[1]) begin
                        m_rise <= 1'b1;
                        m_data <= hist_d[1];
                    end else begin
                        m_fall <= 1'b1;
                    end
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("level", 32'(hs_level), 32'(m_level));
        check("rise",  32'(hs_rise),  32'(m_rise));
        check("fall",  32'(hs_fall),  32'(m_fall));
        check("data",  32'(data_out), 32'(m_data));
        check("busy",  32'(busy),     32'(m_run != 0));
        if (hs_rise && hs_fall) check("strobe_excl", 32'(1), 32'(0));
        if (hs_rise) n_rise++;
        if (hs_fall) n_fall++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count edges until the requested strobe is seen; -1 if it never comes.
    task automatic wait_strobe(input bit want_rise, input int max_edges, output int lat);
        lat = -1;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (want_rise ? hs_rise : hs_fall) begin
                lat = i;
                break;
            end
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 32'(hs_level), 32'(0));
        check({tag, "_rise"},  32'(hs_rise),  32'(0));
        check({tag, "_fall"},  32'(hs_fall),  32'(0));
        check({tag, "_data"},  32'(data_out), 32'(0));
        check({tag, "_busy"},  32'(busy),     32'(0));
    endtask

    initial begin
        int lat;
        int r0;
        int f0;
        reset_n  = 1'b0;
        hs_raw   = 1'b0;
        data_raw = '0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Asynchronous reset from the HIGH state with hs_raw still high.
        data_raw = 8'h5A;
        hs_raw   = 1'b1;
        tick(LAT + 2);
        check("pre_rst_level", 32'(hs_level), 32'(1));
        #2 reset_n = 1'b0;
        #1 check_all_zero("rst");
        hs_raw = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(4);

        // Clean press and release.
        data_raw = 8'hA5;
        hs_raw   = 1'b1;
        wait_strobe(1'b1, LAT + 4, lat);
        check("press_lat", 32'(lat), 32'(LAT));
        check("press_data", 32'(data_out), 32'(8'hA5));
        check("press_level", 32'(hs_level), 32'(1));
        data_raw = 8'h11;
        hs_raw   = 1'b0;
        wait_strobe(1'b0, LAT + 4, lat);
        check("release_lat", 32'(lat), 32'(LAT));
        check("release_data", 32'(data_out), 32'(8'hA5));
        tick(3);

        // Bounce before a stable press.
        r0 = n_rise;
        for (int i = 0; i < 4; i++) begin
            hs_raw = (i % 2 == 0);
            tick(2);
        end
        hs_raw = 1'b1;
        wait_strobe(1'b1, LAT + 4, lat);
        check("bounce_lat", 32'(lat), 32'(LAT));
        check("bounce_nrise", 32'(n_rise - r0), 32'(1));
        hs_raw = 1'b0;
        wait_strobe(1'b0, LAT + 4, lat);
        check("bounce_rel_lat", 32'(lat), 32'(LAT));

        // Data changes while high are ignored.
        data_raw = 8'h3C;
        hs_raw   = 1'b1;
        wait_strobe(1'b1, LAT + 4, lat);
        check("hold_lat", 32'(lat), 32'(LAT));
        r0 = n_rise;
        f0 = n_fall;
        data_raw = 8'hFF;
        tick(20);
        check("hold_data", 32'(data_out), 32'(8'h3C));
        check("hold_nstrobe", 32'((n_rise - r0) + (n_fall - f0)), 32'(0));
        hs_raw = 1'b0;
        wait_strobe(1'b0, LAT + 4, lat);
        check("hold_rel_lat", 32'(lat), 32'(LAT));
        tick(3);

        // Reset during qualification, then hs_raw held high through release.
        r0 = n_rise;
        data_raw = 8'h77;
        hs_raw   = 1'b1;
        tick(3);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midq");
        tick(1);
        check("midq_nrise", 32'(n_rise - r0), 32'(0));
        reset_n = 1'b1;
        wait_strobe(1'b1, LAT + 4, lat);
        check("midq_lat", 32'(lat), 32'(LAT));
        check("midq_data", 32'(data_out), 32'(8'h77));
        hs_raw = 1'b0;
        wait_strobe(1'b0, LAT + 4, lat);
        tick(3);

        // Four presses carrying consecutive words.
        r0 = n_rise;
        f0 = n_fall;
        for (int w = 1; w <= 4; w++) begin
            data_raw = WORD_W'(w);
            hs_raw   = 1'b1;
            wait_strobe(1'b1, LAT + 4, lat);
            check("seq_data", 32'(data_out), 32'(w));
            hs_raw = 1'b0;
            wait_strobe(1'b0, LAT + 4, lat);
            check("seq_fall_lat", 32'(lat), 32'(LAT));
        end
        check("seq_nrise", 32'(n_rise - r0), 32'(4));
        check("seq_nfall", 32'(n_fall - f0), 32'(4));

        // Random switch activity, checked cycle by cycle against the model.
        for (int s = 0; s < 80; s++) begin
            hs_raw   = 1'($urandom_range(0, 1));
            data_raw = WORD_W'($urandom);
            tick($urandom_range(1, 9));
        end
        hs_raw = 1'b0;
        tick(LAT + 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
